// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns set/reset/toggle requests into guarded S/R pulses
// for a downstream SR NOR latch. Optional readback check: SR_DRIVER_READBACK_EN.
module sr_latch_driver #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    output logic       s_out,
    output logic       r_out,
    output logic       q_exp,
    input  logic       q_in,
    output logic       mismatch
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_W - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       target;
    logic       accept;
    logic       is_cmd;
    logic       gap_done;

    assign accept   = req_valid & req_ready;
    assign is_cmd   = (req_op != 2'b00);
    assign gap_done = (state == GAP) && (cnt == 4'd0);

    // Target latch level implied by the opcode; toggle inverts the tracked state
    always_comb begin
        target = q_exp;
        unique case (req_op)
            2'b01:   target = 1'b1;
            2'b10:   target = 1'b0;
            2'b11:   target = ~q_exp;
            default: target = q_exp;
        endcase
    end

    // Sequencer: IDLE -> PULSE (one drive high) -> GAP (both low) -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            s_out     <= 1'b0;
            r_out     <= 1'b0;
            q_exp     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && is_cmd) begin
                        state     <= PULSE;
                        cnt       <= PULSE_LD;
                        req_ready <= 1'b0;
                        q_exp     <= target;
                        s_out     <= target;
                        r_out     <= ~target;
                    end
                end
                PULSE: begin
                    if (cnt == 4'd0) begin
                        state <= GAP;
                        cnt   <= GAP_LD;
                        s_out <= 1'b0;
                        r_out <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                GAP: begin
                    if (cnt == 4'd0) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 4'd0;
                    req_ready <= 1'b1;
                    s_out     <= 1'b0;
                    r_out     <= 1'b0;
                end
            endcase
        end
    end

`ifdef SR_DRIVER_READBACK_EN
    // Sticky flag: latch Q disagreed with the tracked state when a command retired
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (gap_done && (q_in != q_exp)) begin
            mismatch <= 1'b1;
        end
    end
`else
    logic unused_readback;
    assign unused_readback = q_in ^ gap_done;
    assign mismatch        = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed bench with an expected-trace scoreboard
// for the default instance plus parameter-corner instances.
module tb_sr_latch_driver;

    localparam int PW0 = 2;
    localparam int GW0 = 1;
`ifdef SR_DRIVER_READBACK_EN
    localparam logic EXP_MM = 1'b1;
`else
    localparam logic EXP_MM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic       force0 = 1'b0;
    logic       lq = 1'b0;
    logic       q_in;
    logic [3:0] rdy, s, r, q, mm;

    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;
    logic mq = 1'b0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    // NOR latch model driven by the default instance
    always @(s[0] or r[0]) begin
        if (s[0]) lq = 1'b1;
        else if (r[0]) lq = 1'b0;
    end

    assign q_in = force0 ? 1'b0 : lq;

    sr_latch_driver #(.PULSE_W(PW0), .GAP_W(GW0)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_ready(rdy[0]), .s_out(s[0]), .r_out(r[0]), .q_exp(q[0]),
        .q_in(q_in), .mismatch(mm[0])
    );
    sr_latch_driver #(.PULSE_W(4), .GAP_W(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_ready(rdy[1]), .s_out(s[1]), .r_out(r[1]), .q_exp(q[1]),
        .q_in(q_in), .mismatch(mm[1])
    );
    sr_latch_driver #(.PULSE_W(1), .GAP_W(1)) u2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_ready(rdy[2]), .s_out(s[2]), .r_out(r[2]), .q_exp(q[2]),
        .q_in(q_in), .mismatch(mm[2])
    );
    sr_latch_driver #(.PULSE_W(15), .GAP_W(15)) u3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_ready(rdy[3]), .s_out(s[3]), .r_out(r[3]), .q_exp(q[3]),
        .q_in(q_in), .mismatch(mm[3])
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, check invariant and trace, then step off it
    task automatic tick();
        logic [3:0] e;
        @(negedge clk);
        if (mon_en) begin
            chk("no_s_and_r", 16'(s & r), 16'h0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("trace_s_r_q_rdy", {12'h0, s[0], r[0], q[0], rdy[0]},
                    {12'h0, e});
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        tick();
        chk("reset_vals", {11'h0, s[0], r[0], q[0], rdy[0], mm[0]},
            16'b00010);
        rst = 1'b0;
        mq = 1'b0;
    endtask

    // Issue one request to an idle u0 and queue the cycle-by-cycle trace
    task automatic cmd(input logic [1:0] op, input logic [1:0] alt,
                       input bit use_alt);
        logic t;
        req_valid = 1'b1;
        req_op = op;
        if (op == 2'b00) begin
            sb.push_back({2'b00, mq, 1'b1});
            tick();
            req_valid = 1'b0;
            return;
        end
        t = (op == 2'b01) ? 1'b1 : (op == 2'b10) ? 1'b0 : ~mq;
        mq = t;
        for (int i = 0; i < PW0; i++) sb.push_back({t, ~t, t, 1'b0});
        for (int i = 0; i < GW0; i++) sb.push_back({2'b00, t, 1'b0});
        sb.push_back({2'b00, t, 1'b1});
        tick();
        if (use_alt) req_op = alt;
        repeat (PW0 + GW0) tick();
        req_valid = 1'b0;
    endtask

    initial begin
        int   st2[$];
        int   st3[$];
        int   len3;
        logic p2, p3, seen;

        tick();
        tick();
        mon_en = 1'b1;
        do_reset();

        // set then reset, back-to-back with valid held
        cmd(2'b01, 2'b00, 0);
        cmd(2'b10, 2'b00, 0);

        // three toggles from reset: q 1,0,1
        do_reset();
        cmd(2'b11, 2'b00, 0);
        cmd(2'b11, 2'b00, 0);
        cmd(2'b11, 2'b00, 0);
        chk("toggle_final_q", {15'h0, q[0]}, 16'h1);

        // nops and op change while busy
        cmd(2'b00, 2'b00, 0);
        cmd(2'b10, 2'b01, 1);
        cmd(2'b00, 2'b00, 0);
        cmd(2'b01, 2'b10, 1);
        cmd(2'b00, 2'b00, 0);

        // reset coinciding with a valid request: reset wins
        rst = 1'b1;
        req_valid = 1'b1;
        req_op = 2'b11;
        tick();
        chk("rst_vs_accept", {13'h0, s[0] | r[0], q[0], rdy[0]}, 16'b001);
        rst = 1'b0;
        req_valid = 1'b0;
        mq = 1'b0;
        tick();
        chk("no_accept_after_rst", {15'h0, s[0] | r[0]}, 16'h0);

        // reset on the second pulse cycle of the PULSE_W=4 instance
        req_valid = 1'b1;
        req_op = 2'b01;
        tick();
        req_valid = 1'b0;
        tick();
        chk("u1_pulse_active", {15'h0, s[1]}, 16'h1);
        rst = 1'b1;
        tick();
        chk("u1_mid_rst", {13'h0, s[1], q[1], rdy[1]}, 16'b001);
        rst = 1'b0;
        mq = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen = seen | s[1] | r[1];
        end
        chk("u1_no_replay", {15'h0, seen}, 16'h0);

        // parameter corners with toggle held valid
        do_reset();
        req_valid = 1'b1;
        req_op = 2'b11;
        p2 = 1'b0;
        p3 = 1'b0;
        len3 = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if ((s[2] | r[2]) && !p2) st2.push_back(c);
            if ((s[3] | r[3]) && !p3) st3.push_back(c);
            if (st3.size() == 1 && (s[3] | r[3])) len3++;
            p2 = s[2] | r[2];
            p3 = s[3] | r[3];
        end
        req_valid = 1'b0;
        chk("p1_period_a", 16'(st2[1] - st2[0]), 16'd3);
        chk("p1_period_b", 16'(st2[2] - st2[1]), 16'd3);
        chk("p15_pulse_len", 16'(len3), 16'd15);
        chk("p15_period", 16'(st3[1] - st3[0]), 16'd31);
        do_reset();

        // readback against the latch model
        repeat (10) cmd(2'($urandom_range(1, 3)), 2'b00, 0);
        chk("rb_clean", {15'h0, mm[0]}, 16'h0);
        force0 = 1'b1;
        cmd(2'b01, 2'b00, 0);
        force0 = 1'b0;
        chk("rb_forced", {15'h0, mm[0]}, {15'h0, EXP_MM});
        cmd(2'b10, 2'b00, 0);
        chk("rb_sticky", {15'h0, mm[0]}, {15'h0, EXP_MM});
        do_reset();

        chk("sb_drained", 16'(sb.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Clocked command sequencer that drives the S and R inputs of a downstream SR NOR latch. It accepts set/reset/toggle requests over a valid/ready handshake and converts each into a fixed-width pulse on exactly one of S or R, followed by a mandatory both-low guard gap. It tracks the expected latch state and never presents the forbidden S=R=1 combination. It sits directly upstream of the latch; `s_out`/`r_out` connect to the latch's S/R, and the latch Q returns on `q_in`.

## Interface
- `PULSE_W`, default 2: S/R pulse width in clock cycles; legal range 1..15.
- `GAP_W`, default 1: both-low guard cycles after each pulse; legal range 1..15.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_op`  in  2  request opcode: 00 = nop, 01 = set, 10 = reset, 11 = toggle.
- `req_ready`  out  1  block can accept; a request is accepted on an edge where `req_valid & req_ready` = 1.
- `s_out`  out  1  latch S drive, registered.
- `r_out`  out  1  latch R drive, registered.
- `q_exp`  out  1  expected latch state, registered.
- `q_in`  in  1  latch Q readback; used only when `SR_DRIVER_READBACK_EN` is defined.
- `mismatch`  out  1  sticky readback error flag.

## Operation
- The FSM has three states: IDLE, PULSE and GAP. A 4-bit down-counter `cnt` times each state.
- **IDLE:** `req_ready` = 1, and `s_out` = `r_out` = 0.
- **Accepted nop:** the block stays in IDLE. No pulse is issued, and `q_exp` is unchanged.
- **Accepted set/reset/toggle:**
  - The effective target is 1 for set and 0 for reset. For toggle, the target is `~q_exp` sampled at the accept edge.
  - On the accept edge: state <= PULSE, `cnt` <= PULSE_W-1, `req_ready` <= 0, `q_exp` <= target.
  - Also on the accept edge: `s_out` <= target, `r_out` <= ~target.
- **Redundant requests:** a set when `q_exp` = 1 (or a reset when `q_exp` = 0) still issues a full pulse.
- **PULSE:** when `cnt` = 0, the next edge moves to GAP, sets `cnt` <= GAP_W-1, and clears `s_out` and `r_out`. Otherwise `cnt` decrements.
- **GAP:** when `cnt` = 0, the next edge moves to IDLE and sets `req_ready` <= 1. Otherwise `cnt` decrements.
- **Requests while busy:** `req_valid` asserted while `req_ready` = 0 is ignored. The requester must hold `req_valid` and `req_op` stable until accepted.
- **Invariant:** `s_out & r_out` is never 1, on any cycle, including during reset.
- **Reset values:** `s_out` = 0, `r_out` = 0, `q_exp` = 0, `req_ready` = 1, `mismatch` = 0, state = IDLE, `cnt` = 0.
- **Reset mid-operation:** a reset in PULSE or GAP aborts the command. Outputs take their reset values at that edge, and the in-flight request is discarded, not replayed.
- **Simultaneous `rst` and accept:** reset wins, and the request is not accepted.

## Timing
- Accept at edge k: `s_out`/`r_out` is high for exactly PULSE_W cycles, from edge k to edge k+PULSE_W.
- Both drives are low for GAP_W cycles after that. `req_ready` rises at edge k+PULSE_W+GAP_W.
- Minimum command period (back-to-back valid): PULSE_W+GAP_W+1 cycles. With defaults this is 4.
- `q_exp` reflects the new target one cycle after the accept, i.e. from edge k.
- Nop period: 1 cycle, because ready stays high.

## Configuration
- Macro: `SR_DRIVER_READBACK_EN`.
- **Defined:**
  - On the GAP→IDLE edge, `q_in` is compared with `q_exp`. If they differ, `mismatch` <= 1.
  - `mismatch` is sticky until `rst`. Nops perform no check.
  - No check runs until the first completed non-nop command after reset.
- **Undefined:** `q_in` is ignored, `mismatch` is tied to 0, and the comparison logic is absent. All other timing is identical.

## Test plan
- **Set, then reset (defaults):** after reset, issue op 01, then op 10.
  - Required: `s_out` high for 2 cycles, then 1 gap cycle, `q_exp` = 1.
  - Then `r_out` high for 2 cycles, `q_exp` = 0.
  - Accepts spaced exactly 4 cycles with `req_valid` held high.
- **Toggle ×3 from reset:**
  - Required: `q_exp` sequence 1, 0, 1.
  - Pulses on S, R, S respectively.
  - `s_out & r_out` = 0 on every cycle.
- **Nop and busy-ignore:**
  - op 00: ready stays 1, no pulse, `q_exp` unchanged.
  - Changing `req_op` while `req_ready` = 0 (mid-PULSE) is ignored, and the original command completes unchanged.
- **Reset mid-PULSE (PULSE_W = 4):** assert `rst` for 1 cycle on the 2nd pulse cycle.
  - Required at the next edge: `s_out` = 0, `q_exp` = 0, `req_ready` = 1.
  - No further pulse follows.
- **Parameter corners:**
  - PULSE_W = 1, GAP_W = 1: period is 3 cycles.
  - PULSE_W = 15, GAP_W = 15: pulse lasts 15 cycles, gap lasts 15 cycles, period is 31.
- **Readback (macro defined):** drive `q_in` from an SR NOR latch model.
  - No `mismatch` over 10 random commands.
  - Then force `q_in` = 0 during a set command: `mismatch` = 1 at the GAP→IDLE edge and stays 1 until `rst`.
  - With the macro undefined, the same stimulus leaves `mismatch` = 0.
